freqgen: RTL and testbench
==========================

# freqgen

Master-side reference generator for the WFD125 clock distribution. From the local 125 MHz clock it produces the 125/8 MHz (15.625 MHz) reference that slave channel FPGAs multiply back up by 8. It also emits phase-aligned counter-reset and inhibit strobes, and runs a 22-bit master counter that tracks the slaves' 125 MHz counters cycle-for-cycle.

## Interface
Parameters:
- DIV, 8, divide ratio (fixed at 8; phase counter is 3 bits)
- CW, 22, counter width

Ports:
- clk  in  1  125 MHz system clock; every flop in the block is clocked by it
- reset  in  1  synchronous, active-high block reset
- enable  in  1  1 = generator running; 0 = generator parked
- cnt_reset_req  in  1  single-cycle request to zero the counters (master and slaves)
- inhibit_req  in  1  level request to freeze the counters
- freqout  out  1  15.625 MHz reference output, 50 % duty, registered
- resout  out  1  counter-reset strobe to slaves, one full freqout period wide
- inhout  out  1  inhibit strobe to slaves, changes only on freqout period boundaries
- counter  out  CW  master 125 MHz counter
- phase  out  3  divider phase, 0..7
- busy  out  1  reset request pending or in progress (ARMED or ACTIVE)

## Operation
- Divider:
  - phase increments every clk while enable=1; 7 wraps to 0.
  - freqout=1 in cycles where phase is 0-3 and 0 where phase is 4-7. freqout is driven from a flop, not decoded combinationally.
- Period boundary: the clk edge ending a phase-7 cycle. resout, inhout and the counter-reset decision change only there.
- Reset FSM:
  - IDLE → ARMED on cnt_reset_req=1.
  - ARMED → ACTIVE at a period boundary.
  - A request present in the phase-7 cycle itself is honored at that same boundary, i.e. IDLE → ACTIVE directly.
  - ACTIVE lasts exactly one period (8 cycles) with resout=1.
  - At the end of ACTIVE: go to ACTIVE again if a request arrived during ACTIVE (a pending flag is set); otherwise go to IDLE.
  - Repeated requests while ARMED merge into a single reset.
- busy=1 in ARMED and ACTIVE, and while a request is pending.
- Inhibit: inhibit_req is sampled at each period boundary and loaded into inhout. inhout is therefore held for whole periods. An inhibit pulse shorter than a period is lost unless it covers a phase-7 cycle.
- Counter, evaluated at each edge in priority order:
  1. Boundary that enters ACTIVE → counter=0.
  2. Else, if resout=1 or inhout=1 in the current cycle → hold.
  3. Else → counter+1, wrapping 2^CW−1 → 0.
- Reset and inhibit active together: the counter is zeroed and then held until both strobes are low.
- enable=0:
  - phase holds at 0 and freqout=0.
  - resout=0 and inhout=0.
  - counter holds.
  - A pending or ARMED request is retained. On re-enable, phase restarts at 0 and the request is issued at the first boundary.
  - If enable drops during ACTIVE, the reset is aborted and the FSM returns to ARMED.

## Timing
- reset=1 forces, at the next edge: phase=0, freqout=0, resout=0, inhout=0, counter=0, busy=0, FSM=IDLE, pending cleared. Asserting reset mid-period or during ACTIVE discards all state.
- After reset deasserts with enable=1: the first cycle has phase=0 and freqout=0. phase reaches 1 and freqout goes high one cycle later, and the sequence then runs periodically.
- Reset latency: a request in the phase-p cycle gives resout=1 starting (8−p) cycles later, coinciding with a freqout rising edge.
- counter reads 0 for the first 9 cycles from the start of ACTIVE, then 1, 2, …
- freqout, resout and inhout all toggle on the same edge, so slaves can latch the strobes on the freqout rising edge.

## Test plan
- Reset release with enable=1 → freqout toggles every 4 clk (period 8 clk); counter = cycle count; counter wraps 0x3FFFFF → 0x000000.
- cnt_reset_req pulse at phase 2 → busy next cycle; resout high 6 cycles later, lasting 8 cycles; counter = 0 for 9 cycles, then 1.
- cnt_reset_req in a phase-7 cycle → resout rises on the very next edge; a second request during ACTIVE → a second back-to-back 8-cycle resout period, with the counter staying at 0.
- inhibit_req high for phases 3-7 of period N → inhout=1 for all of period N+1, counter frozen for those 8 cycles; a 3-cycle inhibit_req at phases 1-3 → no inhout.
- enable dropped during ACTIVE → freqout=0, resout=0, busy=1; enable restored → resout is reissued starting from the first boundary.
- reset asserted during ACTIVE with inhout=1 → all outputs 0 on the next edge, FSM IDLE, no resout after release.

Source files
------------

// File: rtl/freqgen.sv
// Master reference generator: divides the 125 MHz clock by 8 into a 50 % reference,
// issues period-aligned counter-reset and inhibit strobes, and runs the master counter.
module freqgen #(
   parameter int DIV = 8,
   parameter int CW  = 22
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   input  logic          cnt_reset_req,
   input  logic          inhibit_req,
   output logic          freqout,
   output logic          resout,
   output logic          inhout,
   output logic [CW-1:0] counter,
   output logic [2:0]    phase,
   output logic          busy
);

   localparam logic [2:0] LastPhase = 3'(DIV - 1);
   localparam logic [2:0] HalfPhase = 3'(DIV / 2);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t        state_q;
   logic          pending_q;
   logic          resout_q;
   logic          busy_q;
   logic [2:0]    phase_q, phase_d;
   logic          freqout_q, freqout_d;
   logic          inhout_q, inhout_d;
   logic [CW-1:0] counter_q, counter_d;
   logic          boundary;
   logic          enterActive;

   // A boundary is the edge that closes a phase-7 cycle; all strobe changes happen there.
   always_comb begin
      boundary    = enable && (phase_q == LastPhase);
      enterActive = 1'b0;
      if (boundary) begin
         unique case (state_q)
            IDLE:    enterActive = cnt_reset_req;
            ARMED:   enterActive = 1'b1;
            ACTIVE:  enterActive = pending_q || cnt_reset_req;
            default: enterActive = 1'b0;
         endcase
      end

      phase_d = 3'd0;
      if (enable && (phase_q != LastPhase)) begin
         phase_d = phase_q + 3'd1;
      end
      freqout_d = enable && (phase_d < HalfPhase);

      inhout_d = inhout_q;
      if (!enable) begin
         inhout_d = 1'b0;
      end else if (boundary) begin
         inhout_d = inhibit_req;
      end

      // Zeroing wins over the freeze, so reset+inhibit leaves the counter parked at 0.
      counter_d = counter_q;
      if (enable) begin
         if (enterActive) begin
            counter_d = '0;
         end else if (!resout_q && !inhout_q) begin
            counter_d = counter_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q   <= 3'd0;
         freqout_q <= 1'b0;
         inhout_q  <= 1'b0;
         counter_q <= '0;
      end else begin
         phase_q   <= phase_d;
         freqout_q <= freqout_d;
         inhout_q  <= inhout_d;
         counter_q <= counter_d;
      end
   end

   // Reset sequencer; dropping enable mid-reset falls back to ARMED so it is reissued.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         resout_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (enterActive) begin
                  state_q  <= ACTIVE;
                  resout_q <= 1'b1;
                  busy_q   <= 1'b1;
               end else if (cnt_reset_req) begin
                  state_q <= ARMED;
                  busy_q  <= 1'b1;
               end
            end
            ARMED: begin
               if (enterActive) begin
                  state_q  <= ACTIVE;
                  resout_q <= 1'b1;
               end
            end
            ACTIVE: begin
               if (!enable) begin
                  state_q   <= ARMED;
                  resout_q  <= 1'b0;
                  pending_q <= 1'b0;
               end else if (boundary) begin
                  pending_q <= 1'b0;
                  if (!enterActive) begin
                     state_q  <= IDLE;
                     resout_q <= 1'b0;
                     busy_q   <= 1'b0;
                  end
               end else if (cnt_reset_req) begin
                  pending_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               pending_q <= 1'b0;
               resout_q  <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign freqout = freqout_q;
   assign resout  = resout_q;
   assign inhout  = inhout_q;
   assign counter = counter_q;
   assign phase   = phase_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_freqgen.sv
// Bench for freqgen: hand-derived vector table plus a cycle model feeding a scoreboard queue.
// A narrow-counter second instance makes the counter wrap reachable in a short run.
module tb_freqgen;

   localparam int CW  = 22;
   localparam int CWW = 6;

   logic clk = 1'b0;
   logic reset = 1'b1, enable = 1'b1, cnt_reset_req = 1'b0, inhibit_req = 1'b0;
   logic freqout, resout, inhout, busy;
   logic [2:0] phase;
   logic [CW-1:0] counter;
   logic wFreqout, wResout, wInhout, wBusy;
   logic [2:0] wPhase;
   logic [CWW-1:0] wCounter;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]  ph;
      logic        fr, rs, ih, bz;
      int unsigned cnt;
   } exp_t;
   exp_t sbq[$];

   typedef struct {
      logic        rst, en, req, inh;
      logic [2:0]  ph;
      logic        fr, rs, bz;
      int unsigned cnt;
   } vec_t;
   vec_t tbl[$];

   int          mState = 0;
   logic        mPend = 1'b0, mFreq = 1'b0, mRes = 1'b0, mInh = 1'b0, mBusy = 1'b0;
   logic [2:0]  mPhase = 3'd0;
   int unsigned mCnt = 0;

   freqgen dut (
      .clk(clk), .reset(reset), .enable(enable), .cnt_reset_req(cnt_reset_req),
      .inhibit_req(inhibit_req), .freqout(freqout), .resout(resout), .inhout(inhout),
      .counter(counter), .phase(phase), .busy(busy)
   );

   freqgen #(.DIV(8), .CW(CWW)) dutw (
      .clk(clk), .reset(reset), .enable(enable), .cnt_reset_req(cnt_reset_req),
      .inhibit_req(inhibit_req), .freqout(wFreqout), .resout(wResout), .inhout(wInhout),
      .counter(wCounter), .phase(wPhase), .busy(wBusy)
   );

   always #5 clk = ~clk;

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Cycle model of the generator, written from the behavioural description.
   task automatic modelStep(input logic r, input logic e, input logic q, input logic i);
      logic bnd, enter;
      int   ns;
      bnd = e && (mPhase == 3'd7);
      if (r) begin
         mState = 0; mPend = 1'b0; mPhase = 3'd0; mFreq = 1'b0;
         mRes = 1'b0; mInh = 1'b0; mBusy = 1'b0; mCnt = 0;
      end else begin
         enter = 1'b0;
         ns    = mState;
         case (mState)
            0: if (q) begin
                  if (bnd) begin ns = 2; enter = 1'b1; end
                  else ns = 1;
               end
            1: if (bnd) begin ns = 2; enter = 1'b1; end
            default: begin
               if (!e) begin
                  ns = 1; mPend = 1'b0;
               end else if (bnd) begin
                  if (mPend || q) enter = 1'b1;
                  else ns = 0;
                  mPend = 1'b0;
               end else if (q) begin
                  mPend = 1'b1;
               end
            end
         endcase
         if (e) begin
            if (enter) mCnt = 0;
            else if (!mRes && !mInh) mCnt = mCnt + 1;
         end
         mInh   = !e ? 1'b0 : (bnd ? i : mInh);
         mState = ns;
         mRes   = (ns == 2);
         mPhase = e ? mPhase + 3'd1 : 3'd0;
         mFreq  = e && (mPhase < 3'd4);
         mBusy  = (ns != 0) || mPend;
      end
   endtask

   task automatic checkOutput();
      exp_t x;
      if (sbq.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue expected entry");
         return;
      end
      x = sbq.pop_front();
      checkField("phase",     32'(phase),    32'(x.ph));
      checkField("freqout",   32'(freqout),  32'(x.fr));
      checkField("resout",    32'(resout),   32'(x.rs));
      checkField("inhout",    32'(inhout),   32'(x.ih));
      checkField("busy",      32'(busy),     32'(x.bz));
      checkField("counter",   32'(counter),  x.cnt & 32'h003F_FFFF);
      checkField("w_phase",   32'(wPhase),   32'(x.ph));
      checkField("w_freqout", 32'(wFreqout), 32'(x.fr));
      checkField("w_resout",  32'(wResout),  32'(x.rs));
      checkField("w_inhout",  32'(wInhout),  32'(x.ih));
      checkField("w_busy",    32'(wBusy),    32'(x.bz));
      checkField("w_counter", 32'(wCounter), x.cnt & 32'h0000_003F);
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic q, input logic i);
      exp_t x;
      reset = r; enable = e; cnt_reset_req = q; inhibit_req = i;
      modelStep(r, e, q, i);
      x.ph = mPhase; x.fr = mFreq; x.rs = mRes; x.ih = mInh; x.bz = mBusy; x.cnt = mCnt;
      sbq.push_back(x);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic waitPhase(input logic [2:0] p, input logic i);
      for (int k = 0; k < 8 && mPhase != p; k++) applyStimulus(1'b0, 1'b1, 1'b0, i);
      if (mPhase != p) begin
         errors++;
         $display("[TB] FAIL wait_phase: got %0d expected %0d", mPhase, p);
      end
   endtask

   task automatic addVec(input logic r, e, q, i, input logic [2:0] ph,
                         input logic fr, rs, bz, input int unsigned cnt);
      vec_t v;
      v.rst = r; v.en = e; v.req = q; v.inh = i;
      v.ph = ph; v.fr = fr; v.rs = rs; v.bz = bz; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   initial begin
      int resCnt, zeroCnt, inhCnt, steps;

      // Reset release, then a request in the phase-2 cycle: resout 6 cycles later for 8 cycles.
      addVec(1,1,0,0, 3'd0, 0,0,0, 0);
      addVec(0,1,0,0, 3'd1, 1,0,0, 1);
      addVec(0,1,0,0, 3'd2, 1,0,0, 2);
      addVec(0,1,1,0, 3'd3, 1,0,1, 3);
      addVec(0,1,0,0, 3'd4, 0,0,1, 4);
      addVec(0,1,0,0, 3'd5, 0,0,1, 5);
      addVec(0,1,0,0, 3'd6, 0,0,1, 6);
      addVec(0,1,0,0, 3'd7, 0,0,1, 7);
      addVec(0,1,0,0, 3'd0, 1,1,1, 0);
      addVec(0,1,0,0, 3'd1, 1,1,1, 0);
      addVec(0,1,0,0, 3'd2, 1,1,1, 0);
      addVec(0,1,0,0, 3'd3, 1,1,1, 0);
      addVec(0,1,0,0, 3'd4, 0,1,1, 0);
      addVec(0,1,0,0, 3'd5, 0,1,1, 0);
      addVec(0,1,0,0, 3'd6, 0,1,1, 0);
      addVec(0,1,0,0, 3'd7, 0,1,1, 0);
      addVec(0,1,0,0, 3'd0, 1,0,0, 0);
      addVec(0,1,0,0, 3'd1, 1,0,0, 1);

      for (int v = 0; v < tbl.size(); v++) begin
         applyStimulus(tbl[v].rst, tbl[v].en, tbl[v].req, tbl[v].inh);
         checkField("tbl_phase",   32'(phase),   32'(tbl[v].ph));
         checkField("tbl_freqout", 32'(freqout), 32'(tbl[v].fr));
         checkField("tbl_resout",  32'(resout),  32'(tbl[v].rs));
         checkField("tbl_busy",    32'(busy),    32'(tbl[v].bz));
         checkField("tbl_counter", 32'(counter), tbl[v].cnt);
      end

      // Free run long enough for the narrow counter to wrap.
      for (int k = 0; k < 70; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

      // Request in a phase-7 cycle, then a second request during ACTIVE.
      waitPhase(3'd7, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkField("res_after_ph7", 32'(resout), 32'd1);
      resCnt  = (resout === 1'b1) ? 1 : 0;
      zeroCnt = (counter === '0) ? 1 : 0;
      for (int k = 1; k < 24; k++) begin
         applyStimulus(1'b0, 1'b1, (k == 2), 1'b0);
         if (resout === 1'b1) resCnt++;
         if (counter === '0) zeroCnt++;
      end
      checkField("b2b_res_cycles",  32'(resCnt),  32'd16);
      checkField("b2b_zero_cycles", 32'(zeroCnt), 32'd17);

      // Inhibit covering phases 3-7 holds a whole period; a phase 1-3 pulse is lost.
      waitPhase(3'd3, 1'b0);
      inhCnt = 0;
      for (int k = 0; k < 13; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, (k < 5));
         if (inhout === 1'b1) inhCnt++;
      end
      checkField("inh_long_cycles", 32'(inhCnt), 32'd8);
      waitPhase(3'd1, 1'b0);
      inhCnt = 0;
      for (int k = 0; k < 13; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, (k < 3));
         if (inhout === 1'b1) inhCnt++;
      end
      checkField("inh_short_cycles", 32'(inhCnt), 32'd0);

      // Enable dropped during ACTIVE, then restored: reset reissued at the first boundary.
      waitPhase(3'd4, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 12 && !mRes; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         checkField("dis_freqout", 32'(freqout), 32'd0);
         checkField("dis_resout",  32'(resout),  32'd0);
         checkField("dis_busy",    32'(busy),    32'd1);
      end
      steps = 0;
      do begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
         steps++;
      end while (resout !== 1'b1 && steps < 20);
      checkField("reissue_latency", 32'(steps), 32'd8);
      for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

      // Reset while ACTIVE with inhout=1 discards everything.
      waitPhase(3'd5, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 12 && !(mRes && mInh); k++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      checkField("rst_phase",   32'(phase),   32'd0);
      checkField("rst_freqout", 32'(freqout), 32'd0);
      checkField("rst_resout",  32'(resout),  32'd0);
      checkField("rst_inhout",  32'(inhout),  32'd0);
      checkField("rst_busy",    32'(busy),    32'd0);
      checkField("rst_counter", 32'(counter), 32'd0);
      resCnt = 0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
         if (resout === 1'b1) resCnt++;
      end
      checkField("post_rst_res", 32'(resCnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
